// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and run-control stage feeding SimpleCPU.
// Holds the PC, gates instruction commit, and tracks halt/fault status
// together with the number of retired instructions.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] MAX_INSTR = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic        Step,
    input  logic        Stop,
    input  logic        Clear,
    input  logic [31:0] NextAddr,
    output logic [31:0] PcOut,
    output logic        CpuEn,
    output logic        Running,
    output logic        Halted,
    output logic        Fault,
    output logic [31:0] FaultAddr,
    output logic [31:0] RetiredCnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_HALTED = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] cnt_inc;
    logic        misaligned;
    logic        self_jump;
    logic        at_limit;

    // The counter can never wrap: the limit check halts the core on the
    // commit that brings it to MAX_INSTR, before any further increment.
    assign cnt_inc    = RetiredCnt + 32'd1;
    assign misaligned = |NextAddr[1:0];
    assign self_jump  = (NextAddr == PcOut);
    assign at_limit   = (cnt_inc == MAX_INSTR);

    // Commit is enabled only while an instruction is actually executing, so
    // it follows the state register (and drops asynchronously with reset).
    assign CpuEn   = (state == ST_RUN) || (state == ST_STEP);
    assign Running = (state == ST_RUN);
    assign Halted  = (state == ST_HALTED);
    assign Fault   = (state == ST_FAULT);

    // Run-control FSM with PC, retire counter and fault capture; Clear beats
    // every other input, and a commit's outcome follows fault > self > limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            PcOut      <= RESET_PC;
            RetiredCnt <= 32'd0;
            FaultAddr  <= 32'd0;
        end else if (Clear) begin
            state      <= ST_IDLE;
            PcOut      <= RESET_PC;
            RetiredCnt <= 32'd0;
            FaultAddr  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Stop) begin
                        state <= ST_IDLE;
                    end else if (Start) begin
                        state <= ST_RUN;
                    end else if (Step) begin
                        state <= ST_STEP;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN, ST_STEP: begin
                    RetiredCnt <= cnt_inc;
                    if (misaligned) begin
                        FaultAddr <= NextAddr;
                        state     <= ST_FAULT;
                    end else if (self_jump) begin
                        state <= ST_HALTED;
                    end else begin
                        PcOut <= NextAddr;
                        if (at_limit) begin
                            state <= ST_HALTED;
                        end else if ((state == ST_STEP) || Stop) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_HALTED, ST_FAULT: begin
                    state <= state;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized run-control traffic
// applied to two sequencers (default limit and MAX_INSTR=4), each compared
// every cycle against a behavioural model of the run-control rules.
module tb_pc_sequencer;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_STEP   = 2;
    localparam int M_HALTED = 3;
    localparam int M_FAULT  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic        step_in = 1'b0;
    logic        stop_in = 1'b0;
    logic        clear_in = 1'b0;
    logic [31:0] next_addr [2];
    logic [31:0] dut_pc [2];
    logic        dut_cpu_en [2];
    logic        dut_running [2];
    logic        dut_halted [2];
    logic        dut_fault [2];
    logic [31:0] dut_fault_addr [2];
    logic [31:0] dut_cnt [2];

    int          checks = 0;
    int          failures = 0;

    longint      max_lim [2] = '{64'h0000_0000_FFFF_FFFF, 64'd4};
    int          m_mode [2] = '{M_IDLE, M_IDLE};
    logic [31:0] m_pc [2] = '{32'd0, 32'd0};
    longint      m_cnt [2] = '{0, 0};
    logic [31:0] m_fa [2] = '{32'd0, 32'd0};

    logic [5:0]  pattern;

    pc_sequencer dut0 (
        .clk(clk), .rst_n(rst_n), .Start(start_in), .Step(step_in),
        .Stop(stop_in), .Clear(clear_in), .NextAddr(next_addr[0]),
        .PcOut(dut_pc[0]), .CpuEn(dut_cpu_en[0]), .Running(dut_running[0]),
        .Halted(dut_halted[0]), .Fault(dut_fault[0]),
        .FaultAddr(dut_fault_addr[0]), .RetiredCnt(dut_cnt[0])
    );

    pc_sequencer #(.MAX_INSTR(32'd4)) dut1 (
        .clk(clk), .rst_n(rst_n), .Start(start_in), .Step(step_in),
        .Stop(stop_in), .Clear(clear_in), .NextAddr(next_addr[1]),
        .PcOut(dut_pc[1]), .CpuEn(dut_cpu_en[1]), .Running(dut_running[1]),
        .Halted(dut_halted[1]), .Fault(dut_fault[1]),
        .FaultAddr(dut_fault_addr[1]), .RetiredCnt(dut_cnt[1])
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs; na_mode 0 = PC+4, 1 = jump-to-self, 2 = lit.
    task automatic applyStimulus(input logic s, input logic st, input logic sp,
                                 input logic cl, input int na_mode,
                                 input logic [31:0] lit);
        start_in = s;
        step_in  = st;
        stop_in  = sp;
        clear_in = cl;
        for (int i = 0; i < 2; i++) begin
            case (na_mode)
                0:       next_addr[i] = m_pc[i] + 32'd4;
                1:       next_addr[i] = m_pc[i];
                default: next_addr[i] = lit;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic checkResetValues(input int i);
        checkOutput($sformatf("d%0d rst PcOut", i), dut_pc[i], 32'd0);
        checkOutput($sformatf("d%0d rst Cnt", i), dut_cnt[i], 32'd0);
        checkOutput($sformatf("d%0d rst FaultAddr", i), dut_fault_addr[i], 32'd0);
        checkOutput($sformatf("d%0d rst flags", i),
                    {28'd0, dut_cpu_en[i], dut_running[i], dut_halted[i], dut_fault[i]},
                    32'd0);
    endtask

    // Behavioural model: applies the run-control rules once per clock edge.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_mode[i] = M_IDLE;
                m_pc[i]   = 32'd0;
                m_cnt[i]  = 0;
                m_fa[i]   = 32'd0;
            end else if (clear_in) begin
                m_mode[i] = M_IDLE;
                m_pc[i]   = 32'd0;
                m_cnt[i]  = 0;
                m_fa[i]   = 32'd0;
            end else if (m_mode[i] == M_IDLE) begin
                if (stop_in)       m_mode[i] = M_IDLE;
                else if (start_in) m_mode[i] = M_RUN;
                else if (step_in)  m_mode[i] = M_STEP;
            end else if (m_mode[i] == M_RUN || m_mode[i] == M_STEP) begin
                m_cnt[i] = m_cnt[i] + 1;
                if (next_addr[i][1:0] != 2'b00) begin
                    m_fa[i]   = next_addr[i];
                    m_mode[i] = M_FAULT;
                end else if (next_addr[i] == m_pc[i]) begin
                    m_mode[i] = M_HALTED;
                end else begin
                    m_pc[i] = next_addr[i];
                    if (m_cnt[i] == max_lim[i])
                        m_mode[i] = M_HALTED;
                    else if (m_mode[i] == M_STEP || stop_in)
                        m_mode[i] = M_IDLE;
                end
            end
        end
    end

    // Compare process: every falling edge out of reset, all outputs vs model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("d%0d PcOut", i), dut_pc[i], m_pc[i]);
                checkOutput($sformatf("d%0d RetiredCnt", i), dut_cnt[i], m_cnt[i][31:0]);
                checkOutput($sformatf("d%0d FaultAddr", i), dut_fault_addr[i], m_fa[i]);
                checkOutput($sformatf("d%0d CpuEn", i), {31'd0, dut_cpu_en[i]},
                            {31'd0, (m_mode[i] == M_RUN) || (m_mode[i] == M_STEP)});
                checkOutput($sformatf("d%0d Running", i), {31'd0, dut_running[i]},
                            {31'd0, m_mode[i] == M_RUN});
                checkOutput($sformatf("d%0d Halted", i), {31'd0, dut_halted[i]},
                            {31'd0, m_mode[i] == M_HALTED});
                checkOutput($sformatf("d%0d Fault", i), {31'd0, dut_fault[i]},
                            {31'd0, m_mode[i] == M_FAULT});
            end
        end
    end

    // Directed scenarios with literal expectations, then random traffic.
    initial begin
        next_addr[0] = 32'd0;
        next_addr[1] = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        checkResetValues(0);
        checkResetValues(1);
        rst_n = 1'b1;

        // Start for one cycle, then five commits of sequential code.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        checkOutput("t1 PcOut", dut_pc[0], 32'h14);
        checkOutput("t1 Cnt", dut_cnt[0], 32'd5);
        checkOutput("t1 Running", {31'd0, dut_running[0]}, 32'd1);
        checkOutput("t1 CpuEn", {31'd0, dut_cpu_en[0]}, 32'd1);
        checkOutput("t5 Halted", {31'd0, dut_halted[1]}, 32'd1);
        checkOutput("t5 Cnt", dut_cnt[1], 32'd4);
        checkOutput("t5 PcOut", dut_pc[1], 32'h10);

        // Run up to 0x20, then jump to self; Start afterwards is ignored.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        checkOutput("t2 pre PcOut", dut_pc[0], 32'h20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1, 32'd0);
        checkOutput("t2 Halted", {31'd0, dut_halted[0]}, 32'd1);
        checkOutput("t2 CpuEn", {31'd0, dut_cpu_en[0]}, 32'd0);
        checkOutput("t2 PcOut", dut_pc[0], 32'h20);
        checkOutput("t2 Cnt", dut_cnt[0], 32'd9);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        checkOutput("t2 sticky", {31'd0, dut_halted[0]}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'd0);

        // Misaligned target faults, then Clear recovers.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2, 32'h33);
        checkOutput("t3 Fault", {31'd0, dut_fault[0]}, 32'd1);
        checkOutput("t3 FaultAddr", dut_fault_addr[0], 32'h33);
        checkOutput("t3 PcOut", dut_pc[0], 32'h8);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'd0);
        checkOutput("t3 clr PcOut", dut_pc[0], 32'd0);
        checkOutput("t3 clr Cnt", dut_cnt[0], 32'd0);
        checkOutput("t3 clr Fault", {31'd0, dut_fault[0]}, 32'd0);

        // Step held for six cycles commits every other cycle.
        pattern = 6'd0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 32'd0);
            pattern = {pattern[4:0], dut_cpu_en[0]};
        end
        checkOutput("t4 pattern", {26'd0, pattern}, 32'b101010);
        checkOutput("t4 PcOut", dut_pc[0], 32'h0C);
        checkOutput("t4 Cnt", dut_cnt[0], 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'd0);

        // Stop together with jump-to-self: halting wins.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1, 32'd0);
        checkOutput("t6 Halted", {31'd0, dut_halted[0]}, 32'd1);
        checkOutput("t6 Running", {31'd0, dut_running[0]}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'd0);

        // Asynchronous reset in the middle of RUN.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        checkOutput("t6 pre Running", {31'd0, dut_running[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetValues(0);
        checkResetValues(1);
        #1;
        rst_n = 1'b1;

        // Randomized traffic with occasional Clear and asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                #1;
                checkResetValues(0);
                checkResetValues(1);
                #1;
                rst_n = 1'b1;
            end
            start_in = ($urandom_range(0, 5) == 0);
            step_in  = ($urandom_range(0, 5) == 0);
            stop_in  = ($urandom_range(0, 7) == 0);
            clear_in = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < 2; i++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 85)
                    next_addr[i] = m_pc[i] + 32'd4;
                else if (r < 90)
                    next_addr[i] = m_pc[i];
                else if (r < 94)
                    next_addr[i] = (m_pc[i] + 32'd4) | 32'($urandom_range(1, 3));
                else
                    next_addr[i] = $urandom() & 32'hFFFF_FFFC;
            end
            @(posedge clk);
            @(negedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
